// File: rtl/async_req_arbiter_pkg.sv
// Shared types and defaults for the asynchronous-request round-robin arbiter.
package async_req_arbiter_pkg;

  localparam int N_DEF       = 4;
  localparam int TIMEOUT_DEF = 16;
  localparam int TIMER_W     = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/async_req_arbiter_sync.sv
// Two-flop synchronizer for one asynchronous request line, synchronously reset.
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // First stage may go metastable; the second stage gives it a full cycle to settle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/async_req_arbiter.sv
// Round-robin arbiter for N asynchronous level-sensitive requesters.
// Requests are synchronized, granted one at a time through IDLE -> GRANT -> RELEASE,
// and every grant is followed by at least one all-zero cycle.
// Optional feature: define ARB_TIMEOUT_EN to bound each grant to TIMEOUT_CYCLES cycles
// and block the timed-out requester until it drops its request.
module async_req_arbiter
  import async_req_arbiter_pkg::*;
#(
  parameter int N              = N_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req_async,
  output logic [N-1:0]         grant,
  output logic                 grant_valid,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 timeout
);

  localparam int IDW = $clog2(N);

  generate
    if (N < 2 || N > 8 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_badParam
      $error("async_req_arbiter: N must be 2..8 and TIMEOUT_CYCLES 2..255");
    end
  endgenerate

  logic [N-1:0]   w_reqSync;
  logic [N-1:0]   w_eligible;
  logic           w_anyEligible;
  logic [IDW-1:0] w_winnerId;

  arb_state_t     r_state;
  arb_state_t     w_stateNext;
  logic [N-1:0]   r_grant;
  logic [N-1:0]   w_grantNext;
  logic [IDW-1:0] r_grantId;
  logic [IDW-1:0] w_grantIdNext;
  logic [IDW-1:0] r_lastId;
  logic [IDW-1:0] w_lastIdNext;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_sync
      sync2 u_sync2 (
        .clk   (clk),
        .reset (reset),
        .i_d   (req_async[gi]),
        .o_q   (w_reqSync[gi])
      );
    end
  endgenerate

`ifdef ARB_TIMEOUT_EN
  logic [TIMER_W-1:0] r_timer;
  logic [TIMER_W-1:0] w_timerNext;
  logic               r_timeout;
  logic               w_timeoutNext;
  logic [N-1:0]       r_blocked;
  logic [N-1:0]       w_blockedNext;

  assign w_eligible = w_reqSync & ~r_blocked;
  assign timeout    = r_timeout;
`else
  assign w_eligible = w_reqSync;
  assign timeout    = 1'b0;
`endif

  // Round-robin search: walk offsets from N down to 1 so the closest requester after r_lastId wins.
  always_comb begin : p_rrSearch
    int             idx;
    logic [IDW-1:0] idxW;
    idx           = 0;
    idxW          = '0;
    w_anyEligible = 1'b0;
    w_winnerId    = '0;
    for (int k = N; k >= 1; k--) begin
      idx = int'(r_lastId) + k;
      if (idx >= N) begin
        idx = idx - N;
      end
      idxW = IDW'(idx);
      if (w_eligible[idxW]) begin
        w_anyEligible = 1'b1;
        w_winnerId    = idxW;
      end
    end
  end

  // Next-state and next-output logic; grant is registered on the IDLE -> GRANT transition.
  always_comb begin : p_fsmNext
    w_stateNext   = r_state;
    w_grantNext   = r_grant;
    w_grantIdNext = r_grantId;
    w_lastIdNext  = r_lastId;
`ifdef ARB_TIMEOUT_EN
    w_timerNext   = r_timer;
    w_timeoutNext = 1'b0;
    w_blockedNext = r_blocked & w_reqSync;
`endif
    case (r_state)
      IDLE: begin
        if (w_anyEligible) begin
          w_stateNext   = GRANT;
          w_grantNext   = {{(N-1){1'b0}}, 1'b1} << w_winnerId;
          w_grantIdNext = w_winnerId;
          w_lastIdNext  = w_winnerId;
`ifdef ARB_TIMEOUT_EN
          w_timerNext   = '0;
`endif
        end
      end
      GRANT: begin
        if (!w_reqSync[r_grantId]) begin
          w_stateNext   = RELEASE;
          w_grantNext   = '0;
          w_grantIdNext = '0;
        end
`ifdef ARB_TIMEOUT_EN
        else if (r_timer == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
          w_stateNext              = RELEASE;
          w_grantNext              = '0;
          w_grantIdNext            = '0;
          w_timeoutNext            = 1'b1;
          w_blockedNext[r_grantId] = 1'b1;
        end else begin
          w_timerNext = r_timer + 1'b1;
        end
`endif
      end
      RELEASE: begin
        w_stateNext   = IDLE;
        w_grantNext   = '0;
        w_grantIdNext = '0;
      end
      default: begin
        w_stateNext   = IDLE;
        w_grantNext   = '0;
        w_grantIdNext = '0;
      end
    endcase
  end

  // State and registered outputs; reset forces the idle, no-grant condition on the same edge.
  always_ff @(posedge clk) begin : p_fsmReg
    if (reset) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_grantId <= '0;
      r_lastId  <= IDW'(N - 1);
`ifdef ARB_TIMEOUT_EN
      r_timer   <= '0;
      r_timeout <= 1'b0;
      r_blocked <= '0;
`endif
    end else begin
      r_state   <= w_stateNext;
      r_grant   <= w_grantNext;
      r_grantId <= w_grantIdNext;
      r_lastId  <= w_lastIdNext;
`ifdef ARB_TIMEOUT_EN
      r_timer   <= w_timerNext;
      r_timeout <= w_timeoutNext;
      r_blocked <= w_blockedNext;
`endif
    end
  end

  assign grant       = r_grant;
  assign grant_valid = |r_grant;
  assign grant_id    = r_grantId;

endmodule

// File: tb/tb_async_req_arbiter.sv
// Directed testbench for async_req_arbiter with N=4 and default timeout length.
module tb_async_req_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] req_async;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] grant_id;
  logic       timeout;

  int nApplied = 0;
  int nMiss    = 0;

  typedef struct {
    string      name;
    logic [3:0] req;
    int         cycles;
    logic [3:0] expGrant;
    logic       expValid;
    logic [1:0] expId;
    logic       expTimeout;
  } vec_t;

  vec_t vecs[17];

  async_req_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .req_async   (req_async),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .timeout     (timeout)
  );

  // Free-running 10 ns clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mkVec(input string n, input logic [3:0] r, input int c,
                                 input logic [3:0] g, input logic v, input logic [1:0] i);
    vec_t t;
    t.name       = n;
    t.req        = r;
    t.cycles     = c;
    t.expGrant   = g;
    t.expValid   = v;
    t.expId      = i;
    t.expTimeout = 1'b0;
    return t;
  endfunction

  task automatic applyStimulus(input logic [3:0] r);
    req_async = r;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] eG, input logic eV,
                             input logic [1:0] eI, input logic eT);
    nApplied++;
    if (grant !== eG || grant_valid !== eV || grant_id !== eI || timeout !== eT) begin
      nMiss++;
      $display("[TB] FAIL %s: got grant=%b valid=%b id=%0d timeout=%b, want grant=%b valid=%b id=%0d timeout=%b",
               name, grant, grant_valid, grant_id, timeout, eG, eV, eI, eT);
    end
  endtask

  task automatic checkValue(input string name, input int act, input int exp);
    nApplied++;
    if (act != exp) begin
      nMiss++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Holds reset over two edges, releasing it 1 ns after the last one.
  task automatic doReset();
    reset     = 1'b1;
    req_async = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] prev;
    logic [1:0] curId;
    logic [1:0] expOrder[5];
    int         seen;
    int         holdCnt;
    int         grantLen;
    bit         done;

    reset     = 1'b1;
    req_async = 4'b0000;

    // Inputs change 1 ns after an edge; a request raised before edge k is granted after edge k+2.
    vecs[0]  = mkVec("reset_state", 4'b0000, 0, 4'b0000, 1'b0, 2'd0);
    vecs[1]  = mkVec("r0_syncing",  4'b0001, 2, 4'b0000, 1'b0, 2'd0);
    vecs[2]  = mkVec("r0_granted",  4'b0001, 1, 4'b0001, 1'b1, 2'd0);
    vecs[3]  = mkVec("r0_held",     4'b0001, 3, 4'b0001, 1'b1, 2'd0);
    vecs[4]  = mkVec("r0_dropping", 4'b0000, 2, 4'b0001, 1'b1, 2'd0);
    vecs[5]  = mkVec("r0_release",  4'b0000, 1, 4'b0000, 1'b0, 2'd0);
    vecs[6]  = mkVec("r0_idle",     4'b0000, 1, 4'b0000, 1'b0, 2'd0);
    vecs[7]  = mkVec("r2_granted",  4'b0100, 3, 4'b0100, 1'b1, 2'd2);
    vecs[8]  = mkVec("r2_dropped",  4'b0000, 3, 4'b0000, 1'b0, 2'd0);
    vecs[9]  = mkVec("rr_wrap_r0",  4'b0101, 3, 4'b0001, 1'b1, 2'd0);
    vecs[10] = mkVec("r0_off_hold", 4'b0100, 2, 4'b0001, 1'b1, 2'd0);
    vecs[11] = mkVec("rr_release",  4'b0100, 1, 4'b0000, 1'b0, 2'd0);
    vecs[12] = mkVec("rr_idle_gap", 4'b0100, 1, 4'b0000, 1'b0, 2'd0);
    vecs[13] = mkVec("rr_next_r2",  4'b0100, 1, 4'b0100, 1'b1, 2'd2);
    vecs[14] = mkVec("all_off",     4'b0000, 4, 4'b0000, 1'b0, 2'd0);
    vecs[15] = mkVec("rr_pick_r3",  4'b1010, 3, 4'b1000, 1'b1, 2'd3);
    vecs[16] = mkVec("final_off",   4'b0000, 4, 4'b0000, 1'b0, 2'd0);

    doReset();
    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].req);
      if (vecs[i].cycles > 0) begin
        tick(vecs[i].cycles);
      end
      checkOutput(vecs[i].name, vecs[i].expGrant, vecs[i].expValid, vecs[i].expId, vecs[i].expTimeout);
    end

    // All four requesting; each drops 3 cycles after its grant and re-raises once released.
    $display("[TB] simultaneous requests");
    doReset();
    expOrder[0] = 2'd0;
    expOrder[1] = 2'd1;
    expOrder[2] = 2'd2;
    expOrder[3] = 2'd3;
    expOrder[4] = 2'd0;
    seen    = 0;
    holdCnt = 0;
    curId   = 2'd0;
    prev    = 4'b0000;
    applyStimulus(4'b1111);
    for (int cyc = 0; cyc < 200 && seen < 5; cyc++) begin
      tick(1);
      checkValue("sim_onehot", ($countones(grant) <= 1) ? 1 : 0, 1);
      checkValue("sim_gap", (grant != 4'b0000 && prev != 4'b0000 && grant != prev) ? 0 : 1, 1);
      checkValue("sim_valid", int'(grant_valid), (grant != 4'b0000) ? 1 : 0);
      if (grant != 4'b0000 && prev == 4'b0000) begin
        checkValue("sim_order", int'(grant_id), int'(expOrder[seen]));
        seen++;
        holdCnt = 3;
        curId   = grant_id;
      end else if (holdCnt > 0) begin
        holdCnt--;
        if (holdCnt == 0) begin
          req_async[curId] = 1'b0;
        end
      end
      if (grant == 4'b0000 && prev != 4'b0000) begin
        req_async[curId] = 1'b1;
      end
      prev = grant;
    end
    checkValue("sim_grant_count", seen, 5);
    applyStimulus(4'b0000);

    // Short pulse on request 1 that falls entirely between two edges.
    $display("[TB] glitch on request 1");
    doReset();
    #2 req_async[1] = 1'b1;
    #4 req_async[1] = 1'b0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(posedge clk);
      #1;
      checkValue("glitch_onehot", ($countones(grant) <= 1) ? 1 : 0, 1);
      if (cyc == 3) begin
        checkOutput("glitch_settled", 4'b0000, 1'b0, 2'd0, 1'b0);
      end
    end

    // One-edge reset during a grant, request held throughout.
    $display("[TB] reset mid-grant");
    doReset();
    applyStimulus(4'b0010);
    tick(3);
    checkOutput("mid_grant_r1", 4'b0010, 1'b1, 2'd1, 1'b0);
    reset = 1'b1;
    tick(1);
    checkOutput("mid_reset_clear", 4'b0000, 1'b0, 2'd0, 1'b0);
    reset = 1'b0;
    tick(2);
    checkOutput("post_reset_wait", 4'b0000, 1'b0, 2'd0, 1'b0);
    tick(1);
    checkOutput("post_reset_grant", 4'b0010, 1'b1, 2'd1, 1'b0);

`ifdef ARB_TIMEOUT_EN
    // Held request is cut off after 16 grant cycles and stays blocked until it drops.
    $display("[TB] grant timeout");
    doReset();
    applyStimulus(4'b0001);
    tick(3);
    checkOutput("to_first_grant", 4'b0001, 1'b1, 2'd0, 1'b0);
    grantLen = 1;
    done     = 1'b0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      tick(1);
      if (grant == 4'b0001) begin
        grantLen++;
      end else begin
        done = 1'b1;
      end
    end
    checkValue("to_grant_len", grantLen, 16);
    checkOutput("to_pulse", 4'b0000, 1'b0, 2'd0, 1'b1);
    tick(1);
    checkOutput("to_pulse_end", 4'b0000, 1'b0, 2'd0, 1'b0);
    tick(10);
    checkOutput("to_blocked", 4'b0000, 1'b0, 2'd0, 1'b0);
    applyStimulus(4'b0000);
    tick(3);
    applyStimulus(4'b0001);
    done = 1'b0;
    for (int cyc = 0; cyc < 10 && !done; cyc++) begin
      tick(1);
      if (grant == 4'b0001) begin
        done = 1'b1;
      end
    end
    checkValue("to_regrant", int'(done), 1);
`else
    // Without the timeout feature a held grant never ends and timeout never fires.
    $display("[TB] unbounded grant");
    doReset();
    applyStimulus(4'b0001);
    tick(3);
    grantLen = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      checkOutput("unbounded_hold", 4'b0001, 1'b1, 2'd0, 1'b0);
      tick(1);
    end
`endif

    applyStimulus(4'b0000);
    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiss);
    $finish;
  end

endmodule
